// File: rtl/inst_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_enc_pkg
// Description : Shared types and constants for the RV32I instruction encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_LI   = 3'd6,
    FMT_RSVD = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT1 = 2'd1,
    ST_OUT2 = 2'd2
  } state_e;

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  function automatic logic [31:0] addi_word(input logic [4:0] rd,
                                            input logic [4:0] rs1,
                                            input logic [11:0] imm12);
    return {imm12, rs1, 3'b000, rd, OPC_OP_IMM};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder_if
// Description : Request and instruction-word handshake bundle of the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        out_last;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, out_last
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, out_last
  );
endinterface
`default_nettype wire

// File: rtl/inst_encoder_imm_pack.sv
`default_nettype none
// ============================================================================
// Module      : imm_pack
// Description : Scatters an immediate into its I/S/B/U/J instruction bit
//               positions and reports whether it fits the format.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_pack
  import riscv_enc_pkg::*;
(
  input  fmt_e        i_fmt,
  input  logic [31:0] i_imm,
  output logic [31:0] o_imm_bits,
  output logic        o_range_ok
);

  localparam logic signed [31:0] c_i_min = -32'sd2048;
  localparam logic signed [31:0] c_i_max = 32'sd2047;
  localparam logic signed [31:0] c_b_min = -32'sd4096;
  localparam logic signed [31:0] c_b_max = 32'sd4094;
  localparam logic signed [31:0] c_j_min = -32'sd1048576;
  localparam logic signed [31:0] c_j_max = 32'sd1048574;

  logic signed [31:0] w_simm;
  assign w_simm = i_imm;

  always_comb begin
    o_imm_bits = 32'h0;
    o_range_ok = 1'b1;
    case (i_fmt)
      FMT_I: begin
        o_imm_bits = {i_imm[11:0], 20'h0};
        o_range_ok = (w_simm >= c_i_min) && (w_simm <= c_i_max);
      end
      FMT_S: begin
        o_imm_bits = {i_imm[11:5], 13'h0, i_imm[4:0], 7'h0};
        o_range_ok = (w_simm >= c_i_min) && (w_simm <= c_i_max);
      end
      FMT_B: begin
        o_imm_bits = {i_imm[12], i_imm[10:5], 13'h0, i_imm[4:1], i_imm[11], 7'h0};
        o_range_ok = (w_simm >= c_b_min) && (w_simm <= c_b_max) && !i_imm[0];
      end
      FMT_U: begin
        o_imm_bits = {i_imm[31:12], 12'h0};
        o_range_ok = (i_imm[11:0] == 12'h0);
      end
      FMT_J: begin
        o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'h0};
        o_range_ok = (w_simm >= c_j_min) && (w_simm <= c_j_max) && !i_imm[0];
      end
      default: begin
        o_imm_bits = 32'h0;
        o_range_ok = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Packs decoded fields into RV32I words; expands LI to LUI+ADDI.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
  import riscv_enc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  inst_encoder_if.slave  bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_inst;
  logic [31:0] r_pend;
  logic        r_err;
  logic        r_last;

  fmt_e        w_fmt;
  logic [31:0] w_imm_bits;
  logic        w_range_ok;
  logic        w_consume;
  logic        w_in_ready;
  logic        w_accept;
  logic [31:0] w_word1;
  logic [31:0] w_pend;
  logic        w_err1;
  logic        w_last1;
  logic        w_li_small;
  logic [19:0] w_li_hi;

  assign w_fmt = fmt_e'(bus.in_fmt);

  imm_pack u_imm_pack (
    .i_fmt      (w_fmt),
    .i_imm      (bus.in_imm),
    .o_imm_bits (w_imm_bits),
    .o_range_ok (w_range_ok)
  );

  assign bus.out_valid = (r_state != ST_IDLE);
  assign bus.out_inst  = r_inst;
  assign bus.out_err   = r_err;
  assign bus.out_last  = r_last;

  assign w_consume  = bus.out_valid && bus.out_ready;
  assign w_in_ready = (r_state == ST_IDLE) || (w_consume && r_last);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;

  // (imm + 0x800) >> 12: the low 12 bits only carry into hi when imm[11] is set.
  assign w_li_small = ($signed(bus.in_imm) >= -32'sd2048) && ($signed(bus.in_imm) <= 32'sd2047);
  assign w_li_hi    = bus.in_imm[31:12] + {19'h0, bus.in_imm[11]};

  always_comb begin
    w_word1 = NOP_INST;
    w_pend  = 32'h0;
    w_err1  = !w_range_ok;
    w_last1 = 1'b1;
    case (w_fmt)
      FMT_R: w_word1 = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_rd, bus.in_opcode};
      FMT_I: w_word1 = {12'h0, bus.in_rs1, bus.in_funct3, bus.in_rd,
                        bus.in_opcode} | w_imm_bits;
      FMT_S, FMT_B: w_word1 = {7'h0, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               5'h0, bus.in_opcode} | w_imm_bits;
      FMT_U, FMT_J: w_word1 = {20'h0, bus.in_rd, bus.in_opcode} | w_imm_bits;
      FMT_LI: begin
        w_err1 = 1'b0;
        if (w_li_small) begin
          w_word1 = addi_word(bus.in_rd, 5'd0, bus.in_imm[11:0]);
        end else begin
          // lo == imm[11:0] as a 12-bit field, so ADDI is skipped when it is zero.
          w_word1 = {w_li_hi, bus.in_rd, OPC_LUI};
          w_last1 = (bus.in_imm[11:0] == 12'h0);
          w_pend  = addi_word(bus.in_rd, bus.in_rd, bus.in_imm[11:0]);
        end
      end
      default: begin
        w_word1 = NOP_INST;
        w_err1  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_OUT1;
      ST_OUT1, ST_OUT2: begin
        if (w_consume) begin
          if (!r_last)       w_state_nxt = ST_OUT2;
          else if (w_accept) w_state_nxt = ST_OUT1;
          else               w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst <= 32'h0;
      r_pend <= 32'h0;
      r_err  <= 1'b0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_inst <= w_word1;
      r_pend <= w_pend;
      r_err  <= w_err1;
      r_last <= w_last1;
    end else if (w_consume && !r_last) begin
      r_inst <= r_pend;
      r_err  <= 1'b0;
      r_last <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Directed vector bench for inst_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;
  import riscv_enc_pkg::*;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs [18];

  always #5 clk = ~clk;

  inst_encoder_if bus ();

  inst_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int k;
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    for (k = 0; k < 20; k++) begin
      if (bus.in_ready) break;
      @(negedge clk);
    end
    if (k == 20) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_word(input string name, input logic [31:0] inst,
                             input logic err, input logic last);
    chk({name, ".valid"}, {31'h0, bus.out_valid}, 32'd1);
    chk({name, ".inst"},  bus.out_inst, inst);
    chk({name, ".err"},   {31'h0, bus.out_err}, {31'h0, err});
    chk({name, ".last"},  {31'h0, bus.out_last}, {31'h0, last});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //        fmt   op      rd  rs1 rs2 f3    f7  imm            inst           err
    vecs[0]  = '{3'd1, 7'h13, 5,  6,  0,  3'd0, 0, 32'hFFFFFFFF, 32'hFFF30293, 1'b0};
    vecs[1]  = '{3'd3, 7'h63, 0,  1,  2,  3'd0, 0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
    vecs[2]  = '{3'd3, 7'h63, 0,  1,  2,  3'd0, 0, 32'h00000003, 32'h00208163, 1'b1};
    vecs[3]  = '{3'd3, 7'h63, 0,  1,  2,  3'd0, 0, 32'd4094,     32'h7E208FE3, 1'b0};
    vecs[4]  = '{3'd3, 7'h63, 0,  1,  2,  3'd0, 0, 32'd4096,     32'h80208063, 1'b1};
    vecs[5]  = '{3'd1, 7'h13, 5,  6,  0,  3'd0, 0, 32'd2048,     32'h80030293, 1'b1};
    vecs[6]  = '{3'd7, 7'h33, 3,  1,  2,  3'd0, 0, 32'h00000000, 32'h00000013, 1'b1};
    vecs[7]  = '{3'd0, 7'h33, 3,  1,  2,  3'd0, 0, 32'h00000000, 32'h002081B3, 1'b0};
    vecs[8]  = '{3'd2, 7'h23, 0,  1,  2,  3'd2, 0, 32'hFFFFFFF8, 32'hFE20AC23, 1'b0};
    vecs[9]  = '{3'd4, 7'h37, 5,  0,  0,  3'd0, 0, 32'h12345000, 32'h123452B7, 1'b0};
    vecs[10] = '{3'd4, 7'h37, 5,  0,  0,  3'd0, 0, 32'h12345001, 32'h123452B7, 1'b1};
    vecs[11] = '{3'd5, 7'h6F, 1,  0,  0,  3'd0, 0, 32'h00000800, 32'h001000EF, 1'b0};
    vecs[12] = '{3'd5, 7'h6F, 0,  0,  0,  3'd0, 0, 32'hFFFFFFFE, 32'hFFFFF06F, 1'b0};
    vecs[13] = '{3'd5, 7'h6F, 1,  0,  0,  3'd0, 0, 32'h00100000, 32'h800000EF, 1'b1};
    vecs[14] = '{3'd6, 7'h00, 7,  0,  0,  3'd0, 0, 32'hFFFFFFFB, 32'hFFB00393, 1'b0};
    vecs[15] = '{3'd6, 7'h00, 1,  0,  0,  3'd0, 0, 32'h00001000, 32'h000010B7, 1'b0};
    vecs[16] = '{3'd1, 7'h13, 5,  6,  0,  3'd0, 0, 32'hFFFFF800, 32'h80030293, 1'b0};
    vecs[17] = '{3'd5, 7'h6F, 0,  0,  0,  3'd0, 0, 32'h00000003, 32'h0020006F, 1'b1};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst.inst",  bus.out_inst, 32'd0);
    chk("rst.err",   {31'h0, bus.out_err}, 32'd0);
    chk("rst.last",  {31'h0, bus.out_last}, 32'd0);
    chk("rst.in_ready", {31'h0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      send(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
           vecs[i].f3, vecs[i].f7, vecs[i].imm);
      expect_word($sformatf("vec%0d", i), vecs[i].inst, vecs[i].err, 1'b1);
      @(negedge clk);
    end

    // LI split into LUI + ADDI
    send(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    expect_word("li_lui", 32'h12346537, 1'b0, 1'b0);
    chk("li_lui.in_ready", {31'h0, bus.in_ready}, 32'd0);
    @(negedge clk);
    expect_word("li_addi", 32'hFFF50513, 1'b0, 1'b1);
    @(negedge clk);
    chk("li_done.valid", {31'h0, bus.out_valid}, 32'd0);

    // Backpressure during LI, with a pending I request taken on the last consume
    bus.out_ready = 1'b0;
    send(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    drive(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    for (int k = 0; k < 3; k++) begin
      expect_word($sformatf("bp_hold%0d", k), 32'h12346537, 1'b0, 1'b0);
      chk($sformatf("bp_hold%0d.in_ready", k), {31'h0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    chk("bp_lui.in_ready", {31'h0, bus.in_ready}, 32'd0);
    @(negedge clk);
    expect_word("bp_addi", 32'hFFF50513, 1'b0, 1'b1);
    chk("bp_addi.in_ready", {31'h0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    expect_word("bp_next", 32'hFFF30293, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp_done.valid", {31'h0, bus.out_valid}, 32'd0);

    // Back-to-back single-word requests
    drive(3'd1, 7'h13, 5'd1, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) bus.in_rd = 5'(i + 1);
      else       bus.in_valid = 1'b0;
      @(negedge clk);
      expect_word($sformatf("b2b%0d", i), 32'hFFF30013 | (32'(i) << 7), 1'b0, 1'b1);
      chk($sformatf("b2b%0d.in_ready", i), {31'h0, bus.in_ready}, 32'd1);
    end
    @(negedge clk);
    chk("b2b_done.valid", {31'h0, bus.out_valid}, 32'd0);

    // Reset while the LUI is held drops the pending ADDI
    bus.out_ready = 1'b0;
    send(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    expect_word("rst_lui", 32'h12346537, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid.valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_mid.inst", bus.out_inst, 32'd0);
    chk("rst_mid.in_ready", {31'h0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after%0d.valid", k), {31'h0, bus.out_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
